// File: rtl/data_sram_resp_if.sv
// SRAM-style data port between the core (master) and its memory responder (slave).
// Requests are single-cycle and unhandshaked; rdata is registered by the slave.
interface data_sram_resp_if;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport master (
        output sram_en,
        output sram_we,
        output sram_addr,
        output sram_wdata,
        input  sram_rdata
    );

    modport slave (
        input  sram_en,
        input  sram_we,
        input  sram_addr,
        input  sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/data_sram_resp.sv
// Data SRAM responder: word RAM with byte-lane writes plus a small MMIO window
// (LED, switches, free-running timer). Read data returns one cycle after the request.
module data_sram_resp #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] MMIO_BASE  = 32'hbfaf_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    data_sram_resp_if.slave        bus,
    input  logic [7:0]             switch_in,
    output logic [15:0]            led_out
);
    localparam logic [15:0] LED_OFS    = 16'hf020;
    localparam logic [15:0] SWITCH_OFS = 16'hf024;
    localparam logic [15:0] TIMER_OFS  = 16'he000;

    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic                  is_mmio;
    logic [15:0]           mmio_ofs;
    logic                  ram_we;
    logic                  led_we;
    logic                  timer_we;
    logic [15:0]           led_reg;
    logic [15:0]           led_next;
    logic [31:0]           timer;
    logic [31:0]           timer_next;
    logic [31:0]           mmio_rdata;
    logic                  unused_addr_bits;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

    assign is_mmio          = (bus.sram_addr[31:16] == MMIO_BASE[31:16]);
    assign mmio_ofs         = bus.sram_addr[15:0];
    assign ram_idx          = bus.sram_addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^bus.sram_addr[1:0];
    assign led_out          = led_reg;

    always_comb begin
        mmio_rdata = '0;
        led_we     = 1'b0;
        timer_we   = 1'b0;
        ram_we     = bus.sram_en && !is_mmio && (bus.sram_we != 4'b0000);
        if (bus.sram_en && is_mmio) begin
            case (mmio_ofs)
                LED_OFS: begin
                    mmio_rdata = {16'b0, led_reg};
                    led_we     = |bus.sram_we[1:0];
                end
                SWITCH_OFS: mmio_rdata = {24'b0, switch_in};
                TIMER_OFS: begin
                    mmio_rdata = timer;
                    timer_we   = |bus.sram_we;
                end
                default: mmio_rdata = '0;
            endcase
        end

        led_next = led_reg;
        if (bus.sram_we[0]) led_next[7:0]  = bus.sram_wdata[7:0];
        if (bus.sram_we[1]) led_next[15:8] = bus.sram_wdata[15:8];

        // A timer write replaces the count outright, so that cycle skips the increment.
        timer_next = timer_we ? merge_lanes(timer, bus.sram_wdata, bus.sram_we)
                              : timer + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.sram_rdata <= '0;
            led_reg        <= '0;
            timer          <= '0;
        end else begin
            timer <= timer_next;
            if (led_we) led_reg <= led_next;
            if (bus.sram_en) bus.sram_rdata <= is_mmio ? mmio_rdata : mem[ram_idx];
        end
    end

    // RAM keeps its contents across reset; reading the old word above gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (ram_we && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.sram_we[i]) mem[ram_idx][8*i +: 8] <= bus.sram_wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_sram_resp.sv
// Self-checking bench for data_sram_resp: directed scenarios plus randomized traffic
// compared against a behavioural model of RAM words, LED register and timer.
module tb_data_sram_resp;
    localparam logic [31:0] MMIO = 32'hbfaf_0000;

    logic        clk;
    logic        reset;
    logic [7:0]  switch_in;
    logic [15:0] led_out;
    int          checks;
    int          failures;

    data_sram_resp_if bus();

    data_sram_resp #(.ADDR_WIDTH(12), .MMIO_BASE(MMIO)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .switch_in(switch_in),
        .led_out  (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] ref_mem [int];
    logic [15:0] m_led;
    logic [31:0] t_base;
    int          t_mark;
    int          m_cycles;
    logic [31:0] exp_rdata;
    logic        exp_valid;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  lanes);
        logic [31:0] r;
        r = old_word;
        for (int b = 0; b < 4; b++) if (lanes[b]) r[8*b +: 8] = new_word[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] timer_now();
        return t_base + 32'(m_cycles - t_mark);
    endfunction

    // One request cycle: drive, let the edge happen, update the model, return at negedge.
    task automatic cycle(input logic en, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] tval;
        int          idx;
        bus.sram_en    = en;
        bus.sram_we    = we;
        bus.sram_addr  = addr;
        bus.sram_wdata = wdata;
        tval = timer_now();
        @(posedge clk);
        idx = int'(addr[13:2]);
        if (en) begin
            if (addr[31:16] == MMIO[31:16]) begin
                exp_valid = 1'b1;
                case (addr[15:0])
                    16'hf020: begin
                        exp_rdata = {16'b0, m_led};
                        if (we[0]) m_led[7:0]  = wdata[7:0];
                        if (we[1]) m_led[15:8] = wdata[15:8];
                    end
                    16'hf024: exp_rdata = {24'b0, switch_in};
                    16'he000: begin
                        exp_rdata = tval;
                        if (we != 4'b0000) begin
                            t_base = lane_merge(tval, wdata, we);
                            t_mark = m_cycles + 1;
                        end
                    end
                    default: exp_rdata = 32'h0;
                endcase
            end else begin
                exp_valid = ref_mem.exists(idx);
                exp_rdata = exp_valid ? ref_mem[idx] : 32'h0;
                if (we == 4'hf) ref_mem[idx] = wdata;
                else if (we != 4'b0000 && exp_valid) ref_mem[idx] = lane_merge(ref_mem[idx], wdata, we);
            end
        end
        m_cycles++;
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_led     = 16'h0;
        t_base    = 32'h0;
        t_mark    = m_cycles;
        exp_rdata = 32'h0;
        exp_valid = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.sram_en = 1'b0; bus.sram_we = 4'h0; bus.sram_addr = 32'h0; bus.sram_wdata = 32'h0;
        switch_in = 8'h00;
        m_cycles = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.sram_rdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_rdata got=%h want=%h", bus.sram_rdata, 32'h0);
        end
        checks++;
        if (led_out !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_led got=%h want=%h", led_out, 16'h0);
        end
        reset = 1'b0;
        model_reset();
        cycle(1'b1, 4'h0, MMIO + 32'he000, 32'h0);
        checks++;
        if (bus.sram_rdata !== exp_rdata) begin
            failures++;
            $display("[TB] FAIL reset_timer_first got=%h want=%h", bus.sram_rdata, exp_rdata);
        end
    endtask

    task automatic test_word_rw();
        cycle(1'b1, 4'hf, 32'h0000_0040, 32'h1234_5678);
        cycle(1'b1, 4'h0, 32'h0000_0040, 32'h0);
        checks++;
        if (bus.sram_rdata !== 32'h1234_5678 || exp_rdata !== 32'h1234_5678) begin
            failures++;
            $display("[TB] FAIL word_rw got=%h want=%h", bus.sram_rdata, 32'h1234_5678);
        end
    endtask

    task automatic test_byte_lanes();
        cycle(1'b1, 4'hf, 32'h0000_0080, 32'haabb_ccdd);
        cycle(1'b1, 4'b0001, 32'h0000_0080, 32'h0000_11ff);
        checks++;
        if (bus.sram_rdata !== 32'haabb_ccdd) begin
            failures++;
            $display("[TB] FAIL read_first got=%h want=%h", bus.sram_rdata, 32'haabb_ccdd);
        end
        cycle(1'b1, 4'h0, 32'h0000_0080, 32'h0);
        checks++;
        if (bus.sram_rdata !== 32'haabb_ccff) begin
            failures++;
            $display("[TB] FAIL lane0_write got=%h want=%h", bus.sram_rdata, 32'haabb_ccff);
        end
        cycle(1'b1, 4'b1100, 32'h0000_0080, 32'h5566_0000);
        cycle(1'b1, 4'h0, 32'h0000_0080, 32'h0);
        checks++;
        if (bus.sram_rdata !== 32'h5566_ccff) begin
            failures++;
            $display("[TB] FAIL lane23_write got=%h want=%h", bus.sram_rdata, 32'h5566_ccff);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3];
        for (int i = 0; i < 3; i++) begin
            words[i] = $urandom;
            cycle(1'b1, 4'hf, 32'(i * 4), words[i]);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'h0, 32'(i * 4), 32'h0);
            checks++;
            if (bus.sram_rdata !== words[i]) begin
                failures++;
                $display("[TB] FAIL b2b_read%0d got=%h want=%h", i, bus.sram_rdata, words[i]);
            end
        end
        cycle(1'b1, 4'h0, 32'h0000_4000, 32'h0);
        checks++;
        if (bus.sram_rdata !== words[0]) begin
            failures++;
            $display("[TB] FAIL alias_4000 got=%h want=%h", bus.sram_rdata, words[0]);
        end
    endtask

    task automatic test_mmio();
        cycle(1'b1, 4'hf, MMIO + 32'hf020, 32'hffff_a5a5);
        checks++;
        if (led_out !== 16'ha5a5) begin
            failures++;
            $display("[TB] FAIL led_out got=%h want=%h", led_out, 16'ha5a5);
        end
        cycle(1'b1, 4'h0, MMIO + 32'hf020, 32'h0);
        checks++;
        if (bus.sram_rdata !== 32'h0000_a5a5) begin
            failures++;
            $display("[TB] FAIL led_read got=%h want=%h", bus.sram_rdata, 32'h0000_a5a5);
        end
        cycle(1'b0, 4'hf, 32'h0000_0040, $urandom);
        checks++;
        if (bus.sram_rdata !== 32'h0000_a5a5) begin
            failures++;
            $display("[TB] FAIL idle_hold got=%h want=%h", bus.sram_rdata, 32'h0000_a5a5);
        end
        switch_in = 8'h3c;
        cycle(1'b1, 4'hf, MMIO + 32'hf024, 32'hdead_beef);
        checks++;
        if (bus.sram_rdata !== 32'h0000_003c) begin
            failures++;
            $display("[TB] FAIL switch_read got=%h want=%h", bus.sram_rdata, 32'h0000_003c);
        end
        cycle(1'b1, 4'h0, MMIO + 32'h1234, 32'h0);
        checks++;
        if (bus.sram_rdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL unmapped_read got=%h want=%h", bus.sram_rdata, 32'h0);
        end
    endtask

    task automatic test_timer();
        logic [31:0] first;
        cycle(1'b1, 4'hf, MMIO + 32'he000, 32'hffff_fffe);
        repeat (2) cycle(1'b0, 4'h0, 32'h0, 32'h0);
        cycle(1'b1, 4'h0, MMIO + 32'he000, 32'h0);
        checks++;
        if (bus.sram_rdata !== 32'h0 || exp_rdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL timer_wrap got=%h want=%h", bus.sram_rdata, 32'h0);
        end
        first = bus.sram_rdata;
        repeat (4) cycle(1'b0, 4'h0, 32'h0, 32'h0);
        cycle(1'b1, 4'h0, MMIO + 32'he000, 32'h0);
        checks++;
        if (bus.sram_rdata - first !== 32'd5) begin
            failures++;
            $display("[TB] FAIL timer_delta got=%0d want=%0d", bus.sram_rdata - first, 5);
        end
    endtask

    task automatic test_random();
        logic [3:0]  we;
        logic [31:0] addr;
        logic [15:0] ofs [4];
        ofs[0] = 16'hf020; ofs[1] = 16'hf024; ofs[2] = 16'he000; ofs[3] = 16'h1234;
        for (int k = 0; k < 16; k++) cycle(1'b1, 4'hf, 32'h100 + 32'(k * 4), $urandom);
        for (int n = 0; n < 300; n++) begin
            switch_in = 8'($urandom);
            we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 3) == 0)
                addr = MMIO | {16'h0, ofs[$urandom_range(0, 3)]};
            else
                addr = ($urandom & 32'h0000_c000) | 32'h100 | 32'($urandom_range(0, 15) * 4);
            cycle(($urandom_range(0, 4) != 0), we, addr, $urandom);
            checks++;
            if (!exp_valid || bus.sram_rdata !== exp_rdata) begin
                failures++;
                $display("[TB] FAIL random_op%0d addr=%h got=%h want=%h", n, addr, bus.sram_rdata, exp_rdata);
            end
        end
        checks++;
        if (led_out !== m_led) begin
            failures++;
            $display("[TB] FAIL random_led got=%h want=%h", led_out, m_led);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 4'hf, MMIO + 32'hf020, 32'h0000_5a5a);
        bus.sram_en = 1'b1; bus.sram_we = 4'h0; bus.sram_addr = 32'h0000_0080;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.sram_rdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL midreset_rdata got=%h want=%h", bus.sram_rdata, 32'h0);
        end
        checks++;
        if (led_out !== 16'h0) begin
            failures++;
            $display("[TB] FAIL midreset_led got=%h want=%h", led_out, 16'h0);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cycle(1'b1, 4'h0, 32'h0000_0040, 32'h0);
        checks++;
        if (bus.sram_rdata !== exp_rdata || !exp_valid) begin
            failures++;
            $display("[TB] FAIL ram_kept_40 got=%h want=%h", bus.sram_rdata, exp_rdata);
        end
        cycle(1'b1, 4'h0, 32'h0000_0080, 32'h0);
        checks++;
        if (bus.sram_rdata !== 32'h5566_ccff) begin
            failures++;
            $display("[TB] FAIL ram_kept_80 got=%h want=%h", bus.sram_rdata, 32'h5566_ccff);
        end
        cycle(1'b1, 4'h0, MMIO + 32'he000, 32'h0);
        checks++;
        if (bus.sram_rdata !== exp_rdata) begin
            failures++;
            $display("[TB] FAIL timer_after_reset got=%h want=%h", bus.sram_rdata, exp_rdata);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_back_to_back();
        test_mmio();
        test_timer();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
